q3b_fsm_prog: RTL and testbench

- Multi-channel, table-driven Moore FSM; successor to the fixed 5-state x/z sequence FSM.
- CHANNELS independent state registers share one programmable next-state/output table.
- After reset the table holds the legacy 5-state machine, so each channel is drop-in compatible with the fixed block.
- At runtime, software reprograms the table through a single-cycle write port.

---
 rtl/q3b_fsm_prog.sv | 86 ++++++++
 tb/tb_q3b_fsm_prog.sv | 121 ++++++++++++
 2 files changed

// File: rtl/q3b_fsm_prog.sv
// q3b_fsm_prog: multi-channel Moore FSM driven by a shared, runtime-programmable next-state/output table.
// Optional illegal-state detection is enabled by defining Q3B_FSM_ILLEGAL_DET_EN.
module q3b_fsm_prog #(
  parameter int CHANNELS    = 4,
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 5,
  parameter int RESET_STATE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [CHANNELS-1:0]           x,
  output logic [CHANNELS-1:0]           z,
  output logic [CHANNELS*STATE_W-1:0]   state,
  input  logic                          cfg_we,
  input  logic [STATE_W-1:0]            cfg_idx,
  input  logic [STATE_W-1:0]            cfg_next0,
  input  logic [STATE_W-1:0]            cfg_next1,
  input  logic                          cfg_z,
  output logic                          cfg_err,
  output logic [CHANNELS-1:0]           err
);
  localparam int DEPTH = 2**STATE_W;
  localparam logic [STATE_W:0] NS = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] RS = STATE_W'(RESET_STATE);
  logic [STATE_W-1:0] n0_tab [DEPTH];
  logic [STATE_W-1:0] n1_tab [DEPTH];
  logic [DEPTH-1:0]   z_tab;
  logic [STATE_W-1:0] st  [CHANNELS];
  logic [STATE_W-1:0] nxt [CHANNELS];
  logic               cfg_ok;
`ifdef Q3B_FSM_ILLEGAL_DET_EN
  logic [CHANNELS-1:0] ill;
`endif
  assign cfg_ok = {1'b0, cfg_idx} < NS;
  // Reset restores the legacy 5-state machine; advance reads the pre-write table.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        n0_tab[k] <= '0;
        n1_tab[k] <= '0;
      end
      z_tab     <= DEPTH'(5'b11000);
      n1_tab[0] <= STATE_W'(1);
      n0_tab[1] <= STATE_W'(1);
      n1_tab[1] <= STATE_W'(4);
      n0_tab[2] <= STATE_W'(2);
      n1_tab[2] <= STATE_W'(1);
      n0_tab[3] <= STATE_W'(1);
      n1_tab[3] <= STATE_W'(2);
      n0_tab[4] <= STATE_W'(3);
      n1_tab[4] <= STATE_W'(4);
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_we && cfg_ok) begin
        n0_tab[cfg_idx] <= cfg_next0;
        n1_tab[cfg_idx] <= cfg_next1;
        z_tab[cfg_idx]  <= cfg_z;
      end
      cfg_err <= cfg_we && !cfg_ok;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) st[i] <= reset ? RS : nxt[i];
  end
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef Q3B_FSM_ILLEGAL_DET_EN
      ill[i] = {1'b0, st[i]} >= NS;
      nxt[i] = ill[i] ? RS : en ? (x[i] ? n1_tab[st[i]] : n0_tab[st[i]]) : st[i];
      z[i]   = !ill[i] && z_tab[st[i]];
`else
      nxt[i] = en ? (x[i] ? n1_tab[st[i]] : n0_tab[st[i]]) : st[i];
      z[i]   = z_tab[st[i]];
`endif
    end
  end
`ifdef Q3B_FSM_ILLEGAL_DET_EN
  always_ff @(posedge clk) err <= reset ? '0 : err | ill;
`else
  assign err = '0;
`endif
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign state[g*STATE_W +: STATE_W] = st[g];
  end
endmodule

// File: tb/tb_q3b_fsm_prog.sv
// tb_q3b_fsm_prog: directed self-checking bench for q3b_fsm_prog (default parameters).
module tb_q3b_fsm_prog;
  logic        clk = 1'b0;
  logic        reset, en, cfg_we, cfg_z, cfg_err;
  logic [3:0]  x, z, err;
  logic [11:0] state;
  logic [2:0]  cfg_idx, cfg_next0, cfg_next1;
  int n_chk = 0;
  int n_pass = 0;
`ifdef Q3B_FSM_ILLEGAL_DET_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif
  q3b_fsm_prog dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .z(z), .state(state),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_next0(cfg_next0), .cfg_next1(cfg_next1),
    .cfg_z(cfg_z), .cfg_err(cfg_err), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] idx, input logic [2:0] n0, input logic [2:0] n1, input logic zz);
    cfg_we = 1'b1; cfg_idx = idx; cfg_next0 = n0; cfg_next1 = n1; cfg_z = zz;
  endtask
  logic [2:0] seq_s [5] = '{3'd1, 3'd4, 3'd3, 3'd1, 3'd4};
  logic       seq_x [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       seq_z [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  initial begin
    reset = 1'b1; en = 1'b0; x = '0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_next0 = '0; cfg_next1 = '0; cfg_z = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", state, 12'h000);
    chk("rst_z", z, 4'h0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_err", err, 4'h0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x[0] = seq_x[i];
      step();
      chk($sformatf("seq_s0_%0d", i), state[2:0], seq_s[i]);
      chk($sformatf("seq_z0_%0d", i), z[0], seq_z[i]);
    end
    chk("seq_others", state[11:3], 9'h0);
    reset = 1'b1; step(); reset = 1'b0;
    x = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ind_s0_%0d", i), state[2:0], i == 0 ? 3'd1 : 3'd4);
      chk($sformatf("ind_z0_%0d", i), z[0], i == 0 ? 1'b0 : 1'b1);
      chk($sformatf("ind_s1_%0d", i), state[5:3], 3'd0);
      chk($sformatf("ind_z1_%0d", i), z[1], 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = {3'b000, i[0]};
      step();
      chk($sformatf("hold_s0_%0d", i), state[2:0], 3'd4);
      chk($sformatf("hold_z0_%0d", i), z[0], 1'b1);
    end
    en = 1'b1; x = 4'b0000; step();
    chk("hold_exit", state[2:0], 3'd3);
    x[0] = 1'b1; step();
    chk("to2", state[2:0], 3'd2);
    cfg(3'd2, 3'd3, 3'd4, 1'b1); step();
    cfg_we = 1'b0;
    chk("wr_old_entry", state[2:0], 3'd1);
    chk("wr_ok_cfg_err", cfg_err, 1'b0);
    x[0] = 1'b1; step();
    x[0] = 1'b0; step();
    x[0] = 1'b1; step();
    chk("revisit2", state[2:0], 3'd2);
    chk("revisit2_z", z[0], 1'b1);
    x[0] = 1'b0; step();
    chk("new_next0", state[2:0], 3'd3);
    en = 1'b0;
    cfg(3'd0, 3'd0, 3'd1, 1'b1); step();
    cfg_we = 1'b0;
    chk("zwr_s1", state[5:3], 3'd0);
    chk("zwr_z1", z[1], 1'b1);
    cfg(3'd6, 3'd1, 3'd1, 1'b1); step();
    chk("rej_cfg_err", cfg_err, 1'b1);
    chk("rej_s0", state[2:0], 3'd3);
    cfg(3'd3, 3'd1, 3'd6, 1'b1); step();
    cfg_we = 1'b0;
    chk("rej_pulse_end", cfg_err, 1'b0);
    en = 1'b1; x[0] = 1'b1; step();
    chk("ill_s0", state[2:0], 3'd6);
    chk("ill_z0", z[0], 1'b0);
    en = 1'b0; step();
    chk("ill_hold_s0", state[2:0], DET ? 3'd0 : 3'd6);
    chk("ill_err", err, {3'b000, DET});
    en = 1'b1; x[0] = 1'b0; step();
    chk("ill_ret_s0", state[2:0], 3'd0);
    chk("ill_err_sticky", err, {3'b000, DET});
    reset = 1'b1; en = 1'b1; x = 4'hF;
    cfg(3'd1, 3'd2, 3'd2, 1'b1); step();
    reset = 1'b0; cfg_we = 1'b0; en = 1'b0;
    chk("rst2_state", state, 12'h000);
    chk("rst2_z", z, 4'h0);
    chk("rst2_err", err, 4'h0);
    chk("rst2_cfg_err", cfg_err, 1'b0);
    en = 1'b1; x = 4'b0001; step();
    chk("dflt_s0_a", state[2:0], 3'd1);
    step();
    chk("dflt_s0_b", state[2:0], 3'd4);
    x = 4'b0000; step();
    chk("dflt_s0_c", state[2:0], 3'd3);
    chk("dflt_z0_c", z[0], 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
